// File: rtl/wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage_pkg
// Description : Shared widths, load-op encodings and the write-back state
//               encoding used by wb_stage and load_align.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stage_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        LOP_LB  = 3'd0,
        LOP_LH  = 3'd1,
        LOP_LW  = 3'd2,
        LOP_LD  = 3'd3,
        LOP_LBU = 3'd4,
        LOP_LHU = 3'd5,
        LOP_LWU = 3'd6,
        LOP_RSV = 3'd7
    } load_op_e;

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_DONE      = 2'd2
    } wb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Combinational load-data extraction: shifts the aligned
//               doubleword down by the byte offset, then sign/zero extends.
// Revision    : 1.0 - initial release
// ============================================================================
module load_align #(
    parameter int XLEN = wb_stage_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_lo,
    input  logic [2:0]      load_op,
    output logic [XLEN-1:0] value
);
    import wb_stage_pkg::*;

    logic [XLEN-1:0] w_shifted;

    // Byte offset selects the lane; misaligned offsets simply shift further.
    assign w_shifted = rdata >> {addr_lo, 3'b000};

    // Width selection and extension; LD bypasses the shifter entirely.
    always_comb begin
        value = '0;
        case (load_op_e'(load_op))
            LOP_LB:  value = {{(XLEN-8){w_shifted[7]}},   w_shifted[7:0]};
            LOP_LH:  value = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            LOP_LW:  value = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            LOP_LD:  value = rdata;
            LOP_LBU: value = {{(XLEN-8){1'b0}},  w_shifted[7:0]};
            LOP_LHU: value = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            LOP_LWU: value = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
            default: value = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : wb_stage
// Description : Pipeline write-back stage. Accepts one instruction from MEM,
//               waits for load data when needed, and retires it for exactly
//               one cycle (regfile write, commit strobe, instret count).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stage #(
    parameter int XLEN   = wb_stage_pkg::XLEN,
    parameter int REG_AW = wb_stage_pkg::REG_AW
) (
    input  logic              cpu_clk_50M,
    input  logic              cpu_rst_n,      // active-high despite the name
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [XLEN-1:0]   mem_pc,
    input  logic [31:0]       mem_inst,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wa,
    input  logic [XLEN-1:0]   mem_alu_res,
    input  logic              mem_is_load,
    input  logic [2:0]        mem_load_op,
    input  logic [2:0]        mem_addr_lo,
    input  logic              rdata_valid,
    input  logic [XLEN-1:0]   rdata,
    output logic              we,
    output logic [REG_AW-1:0] wa,
    output logic [XLEN-1:0]   wd,
    output logic              commit_valid,
    output logic [XLEN-1:0]   commit_pc,
    output logic [31:0]       commit_inst,
    output logic [63:0]       instret
);
    import wb_stage_pkg::*;

    wb_state_e         state_q, state_d;
    logic              w_accept;
    logic              w_done;
    logic [XLEN-1:0]   w_load_value;

    logic [XLEN-1:0]   pc_q;
    logic [31:0]       inst_q;
    logic              wreg_q;
    logic [REG_AW-1:0] wa_q;
    logic              is_load_q;
    logic [2:0]        load_op_q;
    logic [2:0]        addr_lo_q;
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   load_q;
    logic [XLEN-1:0]   last_pc_q;
    logic [31:0]       last_inst_q;
    logic [63:0]       instret_q;

    // Ready is suppressed while reset is held so nothing is handed over then.
    assign mem_ready = !cpu_rst_n && ((state_q == ST_EMPTY) || (state_q == ST_DONE));
    assign w_accept  = mem_valid && mem_ready;
    assign w_done    = !cpu_rst_n && (state_q == ST_DONE);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata   (rdata),
        .addr_lo (addr_lo_q),
        .load_op (load_op_q),
        .value   (w_load_value)
    );

    // State register.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n) state_q <= ST_EMPTY;
        else           state_q <= state_d;
    end

    // Next-state: DONE is a single cycle unless a new instruction arrives with it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_accept) state_d = mem_is_load ? ST_WAIT_DATA : ST_DONE;
            end
            ST_WAIT_DATA: begin
                if (rdata_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (w_accept) state_d = mem_is_load ? ST_WAIT_DATA : ST_DONE;
                else          state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Instruction fields, captured load data, last-retired trace and instret.
    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst_n) begin
            pc_q        <= '0;
            inst_q      <= '0;
            wreg_q      <= 1'b0;
            wa_q        <= '0;
            is_load_q   <= 1'b0;
            load_op_q   <= '0;
            addr_lo_q   <= '0;
            alu_q       <= '0;
            load_q      <= '0;
            last_pc_q   <= '0;
            last_inst_q <= '0;
            instret_q   <= '0;
        end else begin
            if (w_accept) begin
                pc_q      <= mem_pc;
                inst_q    <= mem_inst;
                wreg_q    <= mem_wreg;
                wa_q      <= mem_wa;
                is_load_q <= mem_is_load;
                load_op_q <= mem_load_op;
                addr_lo_q <= mem_addr_lo;
                alu_q     <= mem_alu_res;
            end
            if ((state_q == ST_WAIT_DATA) && rdata_valid) begin
                load_q <= w_load_value;
            end
            if (w_done) begin
                last_pc_q   <= pc_q;
                last_inst_q <= inst_q;
                instret_q   <= instret_q + 64'd1;
            end
        end
    end

    // Retire outputs; instret already includes the instruction retiring now.
    assign commit_valid = w_done;
    assign we           = w_done && wreg_q && (wa_q != '0);
    assign wa           = w_done ? wa_q : '0;
    assign wd           = w_done ? (is_load_q ? load_q : alu_q) : '0;
    assign commit_pc    = w_done ? pc_q   : last_pc_q;
    assign commit_inst  = w_done ? inst_q : last_inst_q;
    assign instret      = instret_q + {63'd0, w_done};

endmodule
`default_nettype wire
